// File: rtl/block_transfer_sequencer_pkg.sv
// Shared encodings for the block load/store sequencer: addressing modes,
// controller states and word/PC constants.
package block_transfer_sequencer_pkg;

    typedef enum logic [1:0] {
        MODE_IA = 2'b00,
        MODE_IB = 2'b01,
        MODE_DA = 2'b10,
        MODE_DB = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_XFER = 2'b01,
        S_WB   = 2'b10,
        S_FIN  = 2'b11
    } state_t;

    localparam int         WORD_BYTES = 4;
    localparam logic [3:0] PC_REG     = 4'd15;

endpackage

// File: rtl/block_transfer_sequencer_if.sv
// Bus bundle between decode, register file, memory and the sequencer.
// The sequencer uses the master view; the surrounding system uses slave.
interface block_transfer_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic              Start;
    logic              IsLoad;
    logic [1:0]        Mode;
    logic              Writeback;
    logic [3:0]        BaseReg;
    logic [ADDR_W-1:0] BaseAddr;
    logic [15:0]       RegList;
    logic [ADDR_W-1:0] MemRData;
    logic [ADDR_W-1:0] PD;

    logic [3:0]        RF_RW;
    logic [ADDR_W-1:0] RF_PW;
    logic              RF_LE;
    logic [3:0]        RF_RD;
    logic              PcLoad;
    logic [ADDR_W-1:0] PcData;
    logic [ADDR_W-1:0] MemAddr;
    logic              MemWE;
    logic [ADDR_W-1:0] MemWData;
    logic              Busy;
    logic              Done;

    modport master (
        input  Start, IsLoad, Mode, Writeback, BaseReg, BaseAddr, RegList,
               MemRData, PD,
        output RF_RW, RF_PW, RF_LE, RF_RD, PcLoad, PcData, MemAddr, MemWE,
               MemWData, Busy, Done
    );

    modport slave (
        output Start, IsLoad, Mode, Writeback, BaseReg, BaseAddr, RegList,
               MemRData, PD,
        input  RF_RW, RF_PW, RF_LE, RF_RD, PcLoad, PcData, MemAddr, MemWE,
               MemWData, Busy, Done
    );
endinterface

// File: rtl/block_transfer_sequencer_lsb.sv
// Priority encoder returning the index of the lowest set bit of a vector,
// used to step through the register list in ascending order.
module lowest_set_bit_encoder #(
    parameter int W = 16
) (
    input  logic [W-1:0]         vec,
    output logic [$clog2(W)-1:0] idx,
    output logic                 valid
);
    localparam int IW = $clog2(W);

    // Scan from the top down so the last hit is the lowest set bit
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = IW'(i);
                valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/block_transfer_sequencer.sv
// Multi-cycle LDM/STM-style controller: walks the register list one register
// per cycle, drives register file and memory ports, then optionally writes
// the updated base address back before signalling completion.
module block_transfer_sequencer
    import block_transfer_sequencer_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int NREG   = 16
) (
    input logic                      Clk,
    input logic                      Reset,
    block_transfer_sequencer_if.master bus
);
    localparam int CNT_W = $clog2(NREG + 1);
    localparam int IDX_W = $clog2(NREG);
    localparam logic [ADDR_W-1:0] WORD = ADDR_W'(WORD_BYTES);

    function automatic logic [CNT_W-1:0] popcount(input logic [NREG-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < NREG; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    state_t            state_q, state_d;
    logic [NREG-1:0]   list_q, list_clr;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] wb_val_q;
    logic [3:0]        base_reg_q;
    logic              is_load_q;
    logic              wb_q;

    logic [IDX_W-1:0]  idx;
    logic              any;

    logic [ADDR_W-1:0] span;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] wb_val;
    logic              take_wb;

    logic [3:0]        rf_rw;
    logic [ADDR_W-1:0] rf_pw;
    logic              rf_le;
    logic [3:0]        rf_rd;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_data;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wdata;
    logic              busy;
    logic              done;

    lowest_set_bit_encoder #(.W(NREG)) u_lsb (
        .vec   (list_q),
        .idx   (idx),
        .valid (any)
    );

    // Start address, final base value and writeback decision from the request
    always_comb begin
        span = ADDR_W'(popcount(bus.RegList)) * WORD;
        case (mode_t'(bus.Mode))
            MODE_IA: start_addr = bus.BaseAddr;
            MODE_IB: start_addr = bus.BaseAddr + WORD;
            MODE_DA: start_addr = bus.BaseAddr - span + WORD;
            default: start_addr = bus.BaseAddr - span;
        endcase
        if (bus.Mode[1]) wb_val = bus.BaseAddr - span;
        else             wb_val = bus.BaseAddr + span;
        // A loaded base register keeps the loaded value; R15 is never a base target
        take_wb = bus.Writeback && (bus.BaseReg != PC_REG) &&
                  !(bus.IsLoad && bus.RegList[bus.BaseReg]);
    end

    // Controller state register
    always_ff @(posedge Clk) begin
        if (Reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Captured request and running list/address
    always_ff @(posedge Clk) begin
        if (Reset) begin
            list_q     <= '0;
            addr_q     <= '0;
            wb_val_q   <= '0;
            base_reg_q <= '0;
            is_load_q  <= 1'b0;
            wb_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.Start) begin
                        list_q     <= bus.RegList;
                        addr_q     <= start_addr;
                        wb_val_q   <= wb_val;
                        base_reg_q <= bus.BaseReg;
                        is_load_q  <= bus.IsLoad;
                        wb_q       <= take_wb;
                    end
                end
                S_XFER: begin
                    list_q <= list_clr;
                    addr_q <= addr_q + WORD;
                end
                default: ;
            endcase
        end
    end

    // Next state and port drive; Reset blanks all strobes in the aborting cycle
    always_comb begin
        state_d   = state_q;
        list_clr  = list_q;
        list_clr[idx] = 1'b0;
        rf_rw     = '0;
        rf_pw     = '0;
        rf_le     = 1'b0;
        rf_rd     = '0;
        pc_load   = 1'b0;
        pc_data   = '0;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        busy      = 1'b0;
        done      = 1'b0;
        if (!Reset) begin
            case (state_q)
                S_IDLE: begin
                    if (bus.Start) begin
                        state_d = (bus.RegList == '0) ? S_FIN : S_XFER;
                    end
                end
                S_XFER: begin
                    busy     = 1'b1;
                    mem_addr = addr_q;
                    if (is_load_q) begin
                        if (4'(idx) == PC_REG) begin
                            pc_load = 1'b1;
                            pc_data = bus.MemRData;
                        end else begin
                            rf_rw = 4'(idx);
                            rf_pw = bus.MemRData;
                            rf_le = 1'b1;
                        end
                    end else begin
                        rf_rd     = 4'(idx);
                        mem_wdata = bus.PD;
                        mem_we    = 1'b1;
                    end
                    if (!any || list_clr == '0) begin
                        state_d = wb_q ? S_WB : S_FIN;
                    end
                end
                S_WB: begin
                    busy    = 1'b1;
                    rf_rw   = base_reg_q;
                    rf_pw   = wb_val_q;
                    rf_le   = 1'b1;
                    state_d = S_FIN;
                end
                default: begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign bus.RF_RW    = rf_rw;
    assign bus.RF_PW    = rf_pw;
    assign bus.RF_LE    = rf_le;
    assign bus.RF_RD    = rf_rd;
    assign bus.PcLoad   = pc_load;
    assign bus.PcData   = pc_data;
    assign bus.MemAddr  = mem_addr;
    assign bus.MemWE    = mem_we;
    assign bus.MemWData = mem_wdata;
    assign bus.Busy     = busy;
    assign bus.Done     = done;

endmodule
